// File: rtl/rx_ctrl_phy.sv
// Control-channel serial receiver: 1 start bit, 8 data bits MSB first, 2 stop bits.
// Recovers each byte, pulses valid_rx on success and err_rx on a bad stop bit.
module rx_ctrl_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        rx_ctrl,
  input  logic [19:0] tbit_period,
  output logic [7:0]  data_rx,
  output logic        valid_rx,
  output logic        err_rx,
  output logic        busy_rx
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP1, STOP2, DONE, ERR
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic [19:0]            per_q;
  logic [19:0]            half_q;
  logic [19:0]            cnt_q;
  logic [19:0]            cnt_d;
  logic [2:0]             bitcnt_q;
  logic [7:0]             shreg_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   err_q;
  logic                   rxs;
  logic                   fall;
  logic                   smp;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = rxs_prev_q & ~rxs;

  // Flops reset high so that releasing reset never looks like a start edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_ctrl};
      rxs_prev_q <= rxs;
    end
  end

  always_comb begin
    smp = 1'b0;
    case (state_q)
      START:              smp = (cnt_q == half_q - 20'd1);
      DATA, STOP1, STOP2: smp = (cnt_q == per_q - 20'd1);
      default:            smp = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE && !smp) cnt_d = cnt_q + 20'd1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      per_q    <= '0;
      half_q   <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= cnt_d;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            per_q   <= tbit_period;
            half_q  <= tbit_period >> 1;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (smp) begin
            if (!rxs) begin
              state_q  <= DATA;
              bitcnt_q <= 3'd7;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (smp) begin
            shreg_q <= {shreg_q[6:0], rxs};
            if (bitcnt_q == 3'd0) state_q <= STOP1;
            else                  bitcnt_q <= bitcnt_q - 3'd1;
          end
        end
        STOP1: begin
          if (smp) begin
            if (rxs) begin
              state_q <= STOP2;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        STOP2: begin
          if (smp) begin
            if (rxs) begin
              state_q <= DONE;
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_rx  = data_q;
  assign valid_rx = valid_q;
  assign err_rx   = err_q;
  assign busy_rx  = (state_q != IDLE);

endmodule
